// File: rtl/serdes_pkg.sv
// Shared definitions for the CPX link arbiter: header field positions,
// link FSM encoding and a constant-safe ceiling-log2 helper.
package serdes_pkg;

  localparam int HDR_VALID_BIT = 0;
  localparam int HDR_ID_BIT    = 1;
  localparam int HDR_CNT_LSB   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } link_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cpx_link_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on advance the priority moves to the
// requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_ptr;  // index of the requester favoured on a tie

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt        = 2'b00;
      gnt[r_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/cpx_link_arbiter.sv
// Serialises IC and DC fill payloads onto one packet link: a header word
// followed by PAYLOAD_WIDTH/PACKET_WIDTH data beats, LSB chunk first.
module cpx_link_arbiter
  import serdes_pkg::*;
#(
  parameter int    PAYLOAD_WIDTH = 128,
  parameter int    PACKET_WIDTH  = 16,
  parameter int    N_PKTS_BITS   = 4,
  parameter logic  IC_ID         = 1'b0,
  parameter logic  DC_ID         = 1'b1,
  parameter string INST_NAME     = "cpx_link_arbiter"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PAYLOAD_WIDTH-1:0] ic_payload_i,
  input  logic                     ic_payload_valid_i,
  output logic                     ic_payload_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] dc_payload_i,
  input  logic                     dc_payload_valid_i,
  output logic                     dc_payload_ready_o,
  input  logic                     packet_af_i,
  output logic [PACKET_WIDTH-1:0]  packet_o,
  output logic                     busy_o
);

  localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int CNT_W  = (clog2(N_PKTS) < 1) ? 1 : clog2(N_PKTS);

  if (PAYLOAD_WIDTH % PACKET_WIDTH != 0) begin : g_err_div
    $fatal(1, "%s: PAYLOAD_WIDTH must be a multiple of PACKET_WIDTH", INST_NAME);
  end
  if (N_PKTS >= (1 << N_PKTS_BITS)) begin : g_err_cnt
    $fatal(1, "%s: N_PKTS does not fit in N_PKTS_BITS", INST_NAME);
  end
  if (N_PKTS_BITS + 2 > PACKET_WIDTH) begin : g_err_hdr
    $fatal(1, "%s: header fields exceed PACKET_WIDTH", INST_NAME);
  end

  link_state_e              r_state;
  link_state_e              w_state_next;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic [CNT_W-1:0]         w_beat_cnt_next;
  logic [PAYLOAD_WIDTH-1:0] r_shift;
  logic [PAYLOAD_WIDTH-1:0] w_shift_next;
  logic [PACKET_WIDTH-1:0]  r_packet;
  logic [PACKET_WIDTH-1:0]  w_packet_next;

  logic                     w_last_beat;
  logic                     w_opportunity;
  logic                     w_grant;
  logic [1:0]               w_req;
  logic [1:0]               w_gnt;
  logic                     w_win_id;
  logic [PAYLOAD_WIDTH-1:0] w_win_payload;
  logic [PACKET_WIDTH-1:0]  w_header;

  assign w_req         = {dc_payload_valid_i, ic_payload_valid_i};
  assign w_last_beat   = (r_state == ST_DATA) && (r_beat_cnt == CNT_W'(N_PKTS - 1));
  assign w_opportunity = (r_state == ST_IDLE) || w_last_beat;
  // Gated by rst_n so no ready pulse can escape while the link is held in reset.
  assign w_grant       = rst_n && w_opportunity && !packet_af_i && (|w_req);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_grant),
    .gnt     (w_gnt)
  );

  assign ic_payload_ready_o = w_grant && w_gnt[0];
  assign dc_payload_ready_o = w_grant && w_gnt[1];
  assign w_win_id           = w_gnt[1] ? DC_ID : IC_ID;
  assign w_win_payload      = w_gnt[1] ? dc_payload_i : ic_payload_i;

  always_comb begin
    w_header                             = '0;
    w_header[HDR_VALID_BIT]              = 1'b1;
    w_header[HDR_ID_BIT]                 = w_win_id;
    w_header[HDR_CNT_LSB +: N_PKTS_BITS] = N_PKTS_BITS'(N_PKTS);
  end

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_shift_next    = r_shift;
    w_packet_next   = r_packet;
    case (r_state)
      ST_IDLE: begin
        w_packet_next = '0;
        if (w_grant) begin
          w_state_next  = ST_HDR;
          w_packet_next = w_header;
          w_shift_next  = w_win_payload;
        end
      end
      ST_HDR: begin
        w_state_next    = ST_DATA;
        w_beat_cnt_next = '0;
        w_packet_next   = r_shift[PACKET_WIDTH-1:0];
        w_shift_next    = r_shift >> PACKET_WIDTH;
      end
      ST_DATA: begin
        if (w_last_beat) begin
          w_beat_cnt_next = '0;
          if (w_grant) begin
            w_state_next  = ST_HDR;
            w_packet_next = w_header;
            w_shift_next  = w_win_payload;
          end else begin
            w_state_next  = ST_IDLE;
            w_packet_next = '0;
          end
        end else begin
          w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
          w_packet_next   = r_shift[PACKET_WIDTH-1:0];
          w_shift_next    = r_shift >> PACKET_WIDTH;
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_beat_cnt_next = '0;
        w_packet_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_shift    <= '0;
      r_packet   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_shift    <= w_shift_next;
      r_packet   <= w_packet_next;
    end
  end

  assign packet_o = r_packet;
  assign busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cpx_link_arbiter.sv
// Directed and randomised checks of the CPX link arbiter, with a small
// depacketizer model reassembling payloads from the link.
module tb_cpx_link_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ic_payload;
  logic         ic_valid;
  logic         ic_ready;
  logic [127:0] dc_payload;
  logic         dc_valid;
  logic         dc_ready;
  logic         af;
  logic [15:0]  packet;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] p1 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  logic [127:0] p2 = 128'hD007_D006_D005_D004_D003_D002_D001_D000;

  always #5 clk = ~clk;

  cpx_link_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ic_payload_i       (ic_payload),
    .ic_payload_valid_i (ic_valid),
    .ic_payload_ready_o (ic_ready),
    .dc_payload_i       (dc_payload),
    .dc_payload_valid_i (dc_valid),
    .dc_payload_ready_o (dc_ready),
    .packet_af_i        (af),
    .packet_o           (packet),
    .busy_o             (busy)
  );

  function automatic logic [15:0] chunk(input logic [127:0] p, input int k);
    return p[k*16 +: 16];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ic_valid = 1'b1; dc_valid = 1'b0; af = 1'b0;
    ic_payload = p1; dc_payload = p2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (packet !== 16'h0 || busy !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: packet=%h busy=%b ic_rdy=%b dc_rdy=%b, required 0000 0 0 0",
               packet, busy, ic_ready, dc_ready);
    end
    next_cycle();
    ic_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (packet !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: packet=%h busy=%b, required 0000 0", packet, busy);
    end
    $display("reset: done");
  endtask

  // One single-source burst; id selects which source requests.
  task automatic test_single(input logic is_dc);
    logic [127:0] p;
    logic [15:0]  hdr;
    int           pulses;
    p      = is_dc ? p2 : p1;
    hdr    = is_dc ? 16'h0023 : 16'h0021;
    pulses = 0;
    next_cycle();
    ic_valid = !is_dc; dc_valid = is_dc;
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) begin ic_valid = 1'b0; dc_valid = 1'b0; end
      @(negedge clk);
      if ((is_dc ? dc_ready : ic_ready) === 1'b1) pulses++;
      checks++;
      if ((is_dc ? ic_ready : dc_ready) !== 1'b0) begin
        errors++;
        $display("FAIL single_wrong_ready c=%0d: other ready=1, required 0", c);
      end
      checks++;
      if (c == 0 && (packet !== 16'h0 || (is_dc ? dc_ready : ic_ready) !== 1'b1)) begin
        errors++;
        $display("FAIL single_grant c=0: packet=%h ready=%b, required 0000 1",
                 packet, is_dc ? dc_ready : ic_ready);
      end else if (c == 1 && (packet !== hdr || busy !== 1'b1)) begin
        errors++;
        $display("FAIL single_header: packet=%h busy=%b, required %h 1", packet, busy, hdr);
      end else if (c >= 2 && c <= 9 && (packet !== chunk(p, c - 2) || busy !== 1'b1)) begin
        errors++;
        $display("FAIL single_beat%0d: packet=%h busy=%b, required %h 1", c - 2, packet, busy, chunk(p, c - 2));
      end else if (c == 10 && (packet !== 16'h0 || busy !== 1'b0)) begin
        errors++;
        $display("FAIL single_idle_after: packet=%h busy=%b, required 0000 0", packet, busy);
      end
      next_cycle();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_pulse_count: pulses=%0d, required 1", pulses);
    end
    $display("single %s: burst done", is_dc ? "DC" : "IC");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pkt;
    int          ph, bu;
    for (int c = 0; c < 30; c++) begin
      ic_valid = (c <= 18); dc_valid = (c <= 18);
      @(negedge clk);
      if (c == 0 || c >= 28) exp_pkt = 16'h0;
      else begin
        ph = (c - 1) % 9; bu = (c - 1) / 9;
        if (ph == 0) exp_pkt = (bu == 1) ? 16'h0023 : 16'h0021;
        else exp_pkt = chunk((bu == 1) ? p2 : p1, ph - 1);
      end
      checks++;
      if (packet !== exp_pkt || busy !== (c >= 1 && c <= 27)) begin
        errors++;
        $display("FAIL b2b_packet c=%0d: packet=%h busy=%b, required %h %b", c, packet, busy, exp_pkt, c >= 1 && c <= 27);
      end
      checks++;
      if (ic_ready !== (c == 0 || c == 18) || dc_ready !== (c == 9)) begin
        errors++;
        $display("FAIL b2b_ready c=%0d: ic=%b dc=%b, required %b %b", c, ic_ready, dc_ready, c == 0 || c == 18, c == 9);
      end
      next_cycle();
    end
    $display("back_to_back: three bursts done");
  endtask

  task automatic test_almost_full();
    logic [15:0] exp_pkt;
    for (int c = 0; c < 28; c++) begin
      af = (c < 5) || (c >= 8 && c < 17);
      ic_valid = (c <= 5);
      dc_valid = (c >= 8 && c <= 17);
      @(negedge clk);
      if (c == 6) exp_pkt = 16'h0021;
      else if (c >= 7 && c <= 14) exp_pkt = chunk(p1, c - 7);
      else if (c == 18) exp_pkt = 16'h0023;
      else if (c >= 19 && c <= 26) exp_pkt = chunk(p2, c - 19);
      else exp_pkt = 16'h0;
      checks++;
      if (packet !== exp_pkt) begin
        errors++;
        $display("FAIL af_packet c=%0d: packet=%h, required %h", c, packet, exp_pkt);
      end
      checks++;
      if (ic_ready !== (c == 5) || dc_ready !== (c == 17)) begin
        errors++;
        $display("FAIL af_ready c=%0d: ic=%b dc=%b, required %b %b", c, ic_ready, dc_ready, c == 5, c == 17);
      end
      next_cycle();
    end
    af = 1'b0;
    $display("almost_full: stall and mid-burst af done");
  endtask

  task automatic test_reset_mid_burst();
    ic_valid = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) ic_valid = 1'b0;
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (packet !== chunk(p1, 4)) begin
          errors++;
          $display("FAIL rst_pre_beat4: packet=%h, required %h", packet, chunk(p1, 4));
        end
      end else next_cycle();
    end
    dc_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (packet !== 16'h0 || busy !== 1'b0 || dc_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: packet=%h busy=%b dc_rdy=%b, required 0000 0 0", packet, busy, dc_ready);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (packet !== 16'h0 || dc_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_held: packet=%h dc_rdy=%b, required 0000 0", packet, dc_ready);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dc_ready !== 1'b1 || packet !== 16'h0) begin
      errors++;
      $display("FAIL rst_restart_grant: dc_rdy=%b packet=%h, required 1 0000", dc_ready, packet);
    end
    next_cycle();
    dc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (packet !== 16'h0023) begin
      errors++;
      $display("FAIL rst_restart_header: packet=%h, required 0023", packet);
    end
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (packet !== ((k < 8) ? chunk(p2, k) : 16'h0)) begin
        errors++;
        $display("FAIL rst_restart_beat%0d: packet=%h, required %h", k, packet, (k < 8) ? chunk(p2, k) : 16'h0);
      end
    end
    next_cycle();
    $display("reset_mid_burst: truncation and restart done");
  endtask

  task automatic test_random();
    logic [128:0] exp_q[$];
    logic [128:0] exp_item;
    logic [127:0] rx_buf;
    logic         rx_id;
    logic         got_ic, got_dc, exp_busy;
    int           rx_left, rx_k, n_rx;
    got_ic = 1'b0; got_dc = 1'b0; rx_left = 0; rx_k = 0; n_rx = 0;
    rx_buf = '0; rx_id = 1'b0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      if (cyc >= 10000) begin
        ic_valid = 1'b0; dc_valid = 1'b0; af = 1'b0;
      end else begin
        if (ic_valid && (got_ic || $urandom_range(19) == 0)) ic_valid = 1'b0;
        else if (!ic_valid && $urandom_range(2) == 0) begin
          ic_payload = {$urandom, $urandom, $urandom, $urandom}; ic_valid = 1'b1;
        end
        if (dc_valid && (got_dc || $urandom_range(19) == 0)) dc_valid = 1'b0;
        else if (!dc_valid && $urandom_range(2) == 0) begin
          dc_payload = {$urandom, $urandom, $urandom, $urandom}; dc_valid = 1'b1;
        end
        af = ($urandom_range(3) == 0);
      end
      @(negedge clk);
      got_ic = ic_ready; got_dc = dc_ready;
      if (ic_ready || dc_ready) begin
        checks++;
        if ((ic_ready && !ic_valid) || (dc_ready && !dc_valid) || (ic_ready && dc_ready)) begin
          errors++;
          $display("FAIL rnd_ready cyc=%0d: ic_rdy=%b ic_v=%b dc_rdy=%b dc_v=%b", cyc, ic_ready, ic_valid, dc_ready, dc_valid);
        end
        if (ic_ready) exp_q.push_back({1'b0, ic_payload});
        if (dc_ready) exp_q.push_back({1'b1, dc_payload});
      end
      exp_busy = (rx_left > 0) || packet[0];
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL rnd_busy cyc=%0d: busy=%b, required %b", cyc, busy, exp_busy);
      end
      if (rx_left > 0) begin
        rx_buf[rx_k*16 +: 16] = packet;
        rx_k++; rx_left--;
        if (rx_left == 0) begin
          n_rx++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rnd_unexpected_payload cyc=%0d: id=%b data=%h, required none", cyc, rx_id, rx_buf);
          end else begin
            exp_item = exp_q.pop_front();
            if ({rx_id, rx_buf} !== exp_item) begin
              errors++;
              $display("FAIL rnd_payload cyc=%0d: id=%b data=%h, required id=%b data=%h",
                       cyc, rx_id, rx_buf, exp_item[128], exp_item[127:0]);
            end
          end
        end
      end else if (packet !== 16'h0) begin
        checks++;
        if (packet[0] !== 1'b1 || packet[5:2] !== 4'd8 || packet[15:6] !== 10'h0) begin
          errors++;
          $display("FAIL rnd_header cyc=%0d: packet=%h, required valid=1 cnt=8 upper=0", cyc, packet);
        end
        rx_id = packet[1]; rx_left = 8; rx_k = 0; rx_buf = '0;
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0 || rx_left != 0 || n_rx < 100) begin
      errors++;
      $display("FAIL rnd_drain: pending=%0d rx_left=%0d received=%0d, required 0 0 >=100", exp_q.size(), rx_left, n_rx);
    end
    $display("random: %0d payloads reassembled", n_rx);
  endtask

  initial begin
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_almost_full();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
